// File: rtl/lightgate_conditioner_pkg.sv
// lightgate_conditioner_pkg: shared defaults and gate indices for the
// light-gate input conditioner.
package lightgate_conditioner_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 16;
   localparam int unsigned STUCK_CYCLES_DEF    = 1048576;

   typedef enum logic {
      GATE_ONE = 1'b0,
      GATE_TWO = 1'b1
   } gate_idx_e;

endpackage

// File: rtl/lightgate_conditioner_debounce_ch.sv
// lightgate_debounce_ch: one gate channel -- synchronizer, debouncer,
// edge strobes and the optional stuck timer (LIGHTGATE_STUCK_DETECT_EN).
module lightgate_debounce_ch
   import lightgate_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic stuck_o
);

   localparam int unsigned   CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;
   logic          g_q, rise_q, fall_q;

   always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync2_q != lvl_q) begin
         if (cnt_q == DB_LAST) lvl_d = ~lvl_q;
         else                  cnt_d = cnt_q + 1'b1;
      end
   end

   // g_q and the strobes are one register behind lvl_q so they line up.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
         g_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
         g_q     <= lvl_q;
         rise_q  <= lvl_q & ~g_q;
         fall_q  <= ~lvl_q & g_q;
      end
   end

   assign level_o = g_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

`ifdef LIGHTGATE_STUCK_DETECT_EN
   localparam int unsigned   TW    = $clog2(STUCK_CYCLES + 1);
   localparam logic [TW-1:0] T_MAX = TW'(STUCK_CYCLES);

   logic [TW-1:0] tmr_q, tmr_d;
   logic          stuck_q;

   always_comb begin
      tmr_d = '0;
      if (g_q) tmr_d = (tmr_q == T_MAX) ? tmr_q : tmr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmr_q   <= '0;
         stuck_q <= 1'b0;
      end else begin
         tmr_q   <= tmr_d;
         stuck_q <= g_q & (tmr_q == T_MAX);
      end
   end

   assign stuck_o = stuck_q;
`else
   assign stuck_o = (STUCK_CYCLES == 0);
`endif

endmodule

// File: rtl/lightgate_conditioner.sv
// lightgate_conditioner: two independent debounced light-gate channels.
// Stuck detection is built only when LIGHTGATE_STUCK_DETECT_EN is defined.
module lightgate_conditioner
   import lightgate_conditioner_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned STUCK_CYCLES    = STUCK_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic g_one_raw,
   input  logic g_two_raw,
   output logic g_one,
   output logic g_two,
   output logic g_one_rise,
   output logic g_one_fall,
   output logic g_two_rise,
   output logic g_two_fall,
   output logic stuck
);

   logic [1:0] g_w, rise_w, fall_w, stuck_w;

   lightgate_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_ch_one (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (g_one_raw),
      .level_o (g_w[GATE_ONE]),
      .rise_o  (rise_w[GATE_ONE]),
      .fall_o  (fall_w[GATE_ONE]),
      .stuck_o (stuck_w[GATE_ONE])
   );

   lightgate_debounce_ch #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .STUCK_CYCLES    (STUCK_CYCLES)
   ) u_ch_two (
      .clk     (clk),
      .reset   (reset),
      .raw_i   (g_two_raw),
      .level_o (g_w[GATE_TWO]),
      .rise_o  (rise_w[GATE_TWO]),
      .fall_o  (fall_w[GATE_TWO]),
      .stuck_o (stuck_w[GATE_TWO])
   );

   assign g_one      = g_w[GATE_ONE];
   assign g_two      = g_w[GATE_TWO];
   assign g_one_rise = rise_w[GATE_ONE];
   assign g_one_fall = fall_w[GATE_ONE];
   assign g_two_rise = rise_w[GATE_TWO];
   assign g_two_fall = fall_w[GATE_TWO];
   assign stuck      = |stuck_w;

endmodule

// File: tb/tb_lightgate_conditioner.sv
// tb_lightgate_conditioner: scoreboard bench, DEBOUNCE_CYCLES=4,
// STUCK_CYCLES=64; stuck expectations follow LIGHTGATE_STUCK_DETECT_EN.
module tb_lightgate_conditioner;

`ifdef LIGHTGATE_STUCK_DETECT_EN
   localparam logic STK = 1'b1;
`else
   localparam logic STK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   logic g_one_raw, g_two_raw;
   logic g_one, g_two;
   logic g_one_rise, g_one_fall, g_two_rise, g_two_fall;
   logic stuck;

   lightgate_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .STUCK_CYCLES    (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .g_one_raw  (g_one_raw),
      .g_two_raw  (g_two_raw),
      .g_one      (g_one),
      .g_two      (g_two),
      .g_one_rise (g_one_rise),
      .g_one_fall (g_one_fall),
      .g_two_rise (g_two_rise),
      .g_two_fall (g_two_fall),
      .stuck      (stuck)
   );

   always #5 clk = ~clk;

   // {g_one, g_two, one_rise, one_fall, two_rise, two_fall, stuck}
   logic [6:0] ov;
   assign ov = {g_one, g_two, g_one_rise, g_one_fall,
                g_two_rise, g_two_fall, stuck};

   typedef struct {
      int         cyc;
      logic [6:0] vec;
   } ev_t;

   ev_t        sbq[$];
   int         cyc = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   logic       mon_en = 1'b0;
   logic [6:0] prev = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int c, input logic [6:0] v);
      ev_t e;
      e.cyc = c;
      e.vec = v;
      sbq.push_back(e);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every change on the outputs must match the next expected event.
   always @(negedge clk) begin
      if (mon_en) begin
         if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_missed: expected %b at cycle %0d, outputs now %b at cycle %0d",
                     sbq[0].vec, sbq[0].cyc, ov, cyc);
            void'(sbq.pop_front());
         end
         if (ov != prev) begin
            n_chk++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL sb_unexpected: outputs %b -> %b at cycle %0d, none expected",
                        prev, ov, cyc);
            end else begin
               ev_t e;
               e = sbq.pop_front();
               if (e.cyc != cyc || e.vec != ov) begin
                  n_fail++;
                  $display("FAIL sb_event: got %b at cycle %0d, expected %b at cycle %0d",
                           ov, cyc, e.vec, e.cyc);
               end
            end
            prev = ov;
         end
      end
   end

   initial begin
      int c;
      reset     = 1'b1;
      g_one_raw = 1'b0;
      g_two_raw = 1'b0;
      wait_n(3);
      n_chk++;
      if (ov !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_state: got %b, expected 0000000", ov);
      end
      reset  = 1'b0;
      mon_en = 1'b1;
      wait_n(4);

      // Single rise, held, then fall.
      c = cyc;
      g_one_raw = 1'b1;
      push(c + 7, 7'b1010000);
      push(c + 8, 7'b1000000);
      wait_n(20);
      c = cyc;
      g_one_raw = 1'b0;
      push(c + 7, 7'b0001000);
      push(c + 8, 7'b0000000);
      wait_n(12);

      // Short 3-cycle pulse on gate two is filtered.
      g_two_raw = 1'b1;
      wait_n(3);
      g_two_raw = 1'b0;
      wait_n(12);

      // Both gates together.
      c = cyc;
      g_one_raw = 1'b1;
      g_two_raw = 1'b1;
      push(c + 7, 7'b1110100);
      push(c + 8, 7'b1100000);
      wait_n(10);
      c = cyc;
      g_one_raw = 1'b0;
      g_two_raw = 1'b0;
      push(c + 7, 7'b0001010);
      push(c + 8, 7'b0000000);
      wait_n(12);

      // Reset pulse while raw is held high.
      c = cyc;
      g_one_raw = 1'b1;
      push(c + 7, 7'b1010000);
      push(c + 8, 7'b1000000);
      wait_n(8);
      reset = 1'b1;
      push(c + 9, 7'b0000000);
      wait_n(1);
      reset = 1'b0;
      push(c + 16, 7'b1010000);
      push(c + 17, 7'b1000000);
`ifdef LIGHTGATE_STUCK_DETECT_EN
      push(c + 81, 7'b1000001);
`endif
      wait_n(75);

      // Drop after long hold: stuck clears one cycle after g_one falls.
      c = cyc;
      g_one_raw = 1'b0;
      push(c + 7, {6'b000100, STK});
      push(c + 8, 7'b0000000);
      wait_n(12);

      // Toggling every 2 cycles for 100 cycles is filtered.
      for (int i = 0; i < 50; i++) begin
         g_one_raw = (i % 2 == 0);
         g_two_raw = (i % 2 == 1);
         wait_n(2);
      end
      g_one_raw = 1'b0;
      g_two_raw = 1'b0;
      wait_n(12);

      n_chk++;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: %0d events left, expected 0", sbq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/lightgate_conditioner.md
LIGHTGATE_CONDITIONER -- requirements
Module: lightgate_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, meaning the number of consecutive cycles a synchronized input must differ from its debounced level before that level flips; legal range 1..255.
REQ-002 Parameter STUCK_CYCLES, default 1048576, meaning the consecutive active-high cycles after which a debounced gate is flagged stuck; legal range 2..2^24.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 g_one_raw  input  1  asynchronous light-gate 1 sensor level.
REQ-006 g_two_raw  input  1  asynchronous light-gate 2 sensor level.
REQ-007 g_one  output  1  debounced gate-1 level, feeds the lion counter G_one.
REQ-008 g_two  output  1  debounced gate-2 level, feeds the lion counter G_two.
REQ-009 g_one_rise, g_one_fall, g_two_rise, g_two_fall  output  1 each  single-cycle edge strobes of the debounced levels.
REQ-010 stuck  output  1  a debounced gate has been high for at least STUCK_CYCLES cycles.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each channel SHALL hold a debounce counter of width clog2(DEBOUNCE_CYCLES+1) bits.
REQ-013 While sync2 equals the debounced level, the counter SHALL be 0 on the next cycle.
REQ-014 While sync2 differs, the counter SHALL increment; on the cycle it would reach DEBOUNCE_CYCLES, the level SHALL flip and the counter SHALL clear.
REQ-015 Latency: a raw step held steady SHALL appear on g_x exactly DEBOUNCE_CYCLES+2 cycles after the first rising edge sampling the new raw value.
REQ-016 Any excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave g_x and the strobes unchanged.
REQ-017 g_x_rise and g_x_fall SHALL each be high for exactly one cycle, registered, coincident with the cycle g_x first shows the new level; they SHALL never both be high together.
REQ-018 The two channels SHALL be fully independent; simultaneous transitions on both SHALL be processed in the same cycles with no priority.
REQ-019 With DEBOUNCE_CYCLES=1, a change SHALL propagate after 3 cycles and no glitch filtering SHALL occur beyond the synchronizer.

Reset
REQ-020 On reset, synchronizer flops, debounced levels, strobes, counters and stuck timers SHALL all go to 0 on the next rising edge.
REQ-021 Reset asserted mid-debounce SHALL abandon the pending transition; after release, a raw input still high SHALL require the full DEBOUNCE_CYCLES+2 latency again.

Configuration
REQ-022 Macro LIGHTGATE_STUCK_DETECT_EN SHALL gate the stuck-detection feature.
REQ-023 With the macro defined, each channel SHALL hold a saturating timer of clog2(STUCK_CYCLES+1) bits, counting while g_x=1 and clearing when g_x=0; stuck = OR of (timer_x == STUCK_CYCLES), registered.
REQ-024 stuck SHALL deassert on the cycle after the offending g_x returns to 0.
REQ-025 Without the macro, no timer logic SHALL exist and stuck SHALL be constant 0.

Structure
REQ-026 A shared package SHALL hold the default constants for DEBOUNCE_CYCLES and STUCK_CYCLES and a two-entry gate-index enum (GATE_ONE, GATE_TWO).
REQ-027 One sub-module lightgate_debounce_ch SHALL implement synchronizer, debounce counter, level, strobes and optional stuck timer; the top SHALL instantiate it twice and OR the stuck outputs.

Verification (DEBOUNCE_CYCLES=4, STUCK_CYCLES=64)
REQ-028 Reset, then g_one_raw 0->1 held -> g_one=1 and g_one_rise=1 exactly 6 cycles later, for one cycle only.
REQ-029 g_two_raw high for 3 cycles then low -> g_two, g_two_rise and g_two_fall stay 0 throughout.
REQ-030 Both raws rise on the same edge -> g_one and g_two rise on the same cycle, 6 cycles later.
REQ-031 g_one_raw held high 8 cycles, reset pulsed 1 cycle while held, raw still high -> g_one=0 after reset, then rises 6 cycles after reset release.
REQ-032 With macro: g_one held debounced high -> stuck=1 after 64 high cycles plus 1 register cycle; raw dropped -> stuck=0 the cycle after g_one falls. Without macro -> stuck stays 0.
REQ-033 Raw toggling every 2 cycles for 100 cycles -> no change on any output.
